// File: rtl/bdemux_8_reg.sv
// Registered 1-to-8 demultiplexer with byte enables, per-register valid flags,
// a one-cycle write acknowledge and a wrapping accepted-write counter.

module bdemux_8_reg_lane #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        wr,
    input  logic [1:0]  be,
    input  logic [15:0] d,
    output logic [15:0] q
);
    logic [15:0] q_q, q_d;

    // Clear takes effect first, so a same-cycle write lands on RESET_VAL.
    always_comb begin
        q_d = clr ? RESET_VAL : q_q;
        if (wr) begin
            if (be[1]) q_d[15:8] = d[15:8];
            if (be[0]) q_d[7:0]  = d[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= RESET_VAL;
        else     q_q <= q_d;
    end

    assign q = q_q;
endmodule

module bdemux_8_reg #(
    parameter logic [15:0] RESET_VAL = 16'h0000,
    parameter int          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       s,
    input  logic [15:0]      d,
    input  logic [1:0]       be,
    input  logic             we,
    input  logic             clr,
    output logic [15:0]      A,
    output logic [15:0]      B,
    output logic [15:0]      C,
    output logic [15:0]      D,
    output logic [15:0]      E,
    output logic [15:0]      F,
    output logic [15:0]      G,
    output logic [15:0]      H,
    output logic [7:0]       vld,
    output logic             ack,
    output logic [2:0]       ack_sel,
    output logic [CNT_W-1:0] wcnt
);
    logic [7:0][15:0] r;
    logic [7:0]       wsel;

    logic [7:0]       vld_q, vld_d;
    logic             ack_q, ack_d;
    logic [2:0]       ack_sel_q, ack_sel_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;

    // we gates the decode so an unknown s with we=0 never reaches a lane.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign wsel[gi] = we && (s == 3'(gi));
        bdemux_8_reg_lane #(.RESET_VAL(RESET_VAL)) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .wr  (wsel[gi]),
            .be  (be),
            .d   (d),
            .q   (r[gi])
        );
    end

    always_comb begin
        vld_d     = (clr ? 8'h00 : vld_q) | wsel;
        wcnt_d    = (clr ? '0 : wcnt_q) + {{(CNT_W-1){1'b0}}, we};
        ack_d     = we;
        ack_sel_d = we ? s : ack_sel_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= 8'h00;
            ack_q     <= 1'b0;
            ack_sel_q <= 3'd0;
            wcnt_q    <= '0;
        end else begin
            vld_q     <= vld_d;
            ack_q     <= ack_d;
            ack_sel_q <= ack_sel_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign A       = r[0];
    assign B       = r[1];
    assign C       = r[2];
    assign D       = r[3];
    assign E       = r[4];
    assign F       = r[5];
    assign G       = r[6];
    assign H       = r[7];
    assign vld     = vld_q;
    assign ack     = ack_q;
    assign ack_sel = ack_sel_q;
    assign wcnt    = wcnt_q;
endmodule

// File: tb/tb_bdemux_8_reg.sv
// Scoreboard bench for bdemux_8_reg: a reference model pushes the expected
// post-edge state per driven cycle, popped and compared after the edge.

module tb_bdemux_8_reg;
    localparam logic [15:0] RV = 16'h5A5A;
    localparam int          CW = 4;

    typedef struct {
        logic [7:0][15:0] regs;
        logic [7:0]       vld;
        logic             ack;
        logic [2:0]       ack_sel;
        logic [CW-1:0]    wcnt;
    } exp_t;

    logic          clk, rst, we, clr;
    logic [2:0]    s;
    logic [15:0]   d;
    logic [1:0]    be;
    logic [15:0]   A, B, C, D, E, F, G, H;
    logic [7:0]    vld;
    logic          ack;
    logic [2:0]    ack_sel;
    logic [CW-1:0] wcnt;

    bdemux_8_reg #(.RESET_VAL(RV), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .s(s), .d(d), .be(be), .we(we), .clr(clr),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
        .vld(vld), .ack(ack), .ack_sel(ack_sel), .wcnt(wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    exp_t sbq[$];

    logic [7:0][15:0] m_regs;
    logic [7:0]       m_vld;
    logic [CW-1:0]    m_wcnt;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0][15:0] obs_regs();
        return {H, G, F, E, D, C, B, A};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = RV;
        m_vld  = 8'h00;
        m_wcnt = '0;
    endtask

    task automatic chk_reset(input string tag);
        logic [7:0][15:0] o;
        o = obs_regs();
        for (int i = 0; i < 8; i++) chk($sformatf("%s_reg%0d", tag, i), o[i], RV);
        chk({tag, "_vld"},     16'(vld),     16'h0000);
        chk({tag, "_ack"},     16'(ack),     16'h0000);
        chk({tag, "_ack_sel"}, 16'(ack_sel), 16'h0000);
        chk({tag, "_wcnt"},    16'(wcnt),    16'h0000);
    endtask

    task automatic cyc(input logic w, input logic [2:0] sel, input logic [15:0] dat,
                       input logic [1:0] b, input logic c);
        exp_t e;
        logic [7:0][15:0] o;
        @(negedge clk);
        we = w; s = sel; d = dat; be = b; clr = c;
        if (c) model_reset();
        if (w) begin
            if (b[1]) m_regs[sel][15:8] = dat[15:8];
            if (b[0]) m_regs[sel][7:0]  = dat[7:0];
            m_vld[sel] = 1'b1;
            m_wcnt     = m_wcnt + 1'b1;
        end
        e.regs = m_regs; e.vld = m_vld; e.ack = w; e.ack_sel = sel; e.wcnt = m_wcnt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        o = obs_regs();
        for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), o[i], e.regs[i]);
        chk("vld",  16'(vld),  16'(e.vld));
        chk("ack",  16'(ack),  16'(e.ack));
        if (e.ack) chk("ack_sel", 16'(ack_sel), 16'(e.ack_sel));
        chk("wcnt", 16'(wcnt), 16'(e.wcnt));
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; clr = 1'b0; s = 3'd0; d = 16'h0000; be = 2'b00;
        model_reset();
        #3;
        chk_reset("rst_async");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Single full write on the first edge after reset release.
        cyc(1'b1, 3'd3, 16'hBEEF, 2'b11, 1'b0);
        // Byte enables from a cleared state.
        cyc(1'b0, 3'd0, 16'h0000, 2'b00, 1'b1);
        cyc(1'b1, 3'd0, 16'h1234, 2'b11, 1'b0);
        cyc(1'b1, 3'd0, 16'hABCD, 2'b10, 1'b0);
        cyc(1'b1, 3'd0, 16'hFFFF, 2'b00, 1'b0);
        // Unknown select with we low must be inert.
        cyc(1'b0, 3'bxxx, 16'hxxxx, 2'b11, 1'b0);
        // Eight back-to-back writes.
        cyc(1'b0, 3'd0, 16'h0000, 2'b00, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 16'(i) << 8, 2'b11, 1'b0);
        // Consecutive writes to the same register.
        cyc(1'b1, 3'd2, 16'h1111, 2'b11, 1'b0);
        cyc(1'b1, 3'd2, 16'h2222, 2'b01, 1'b0);
        // Clear and write in the same cycle.
        cyc(1'b1, 3'd5, 16'h00FF, 2'b01, 1'b1);
        // Counter wrap: 17 writes after a clear.
        cyc(1'b0, 3'd0, 16'h0000, 2'b00, 1'b1);
        for (int i = 0; i < 17; i++)
            cyc(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 2'b11, 1'b0);
        // Random mix.
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0));

        // Reset asserted between edges during a write cycle aborts it.
        @(negedge clk);
        we = 1'b1; s = 3'd4; d = 16'hCAFE; be = 2'b11; clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_reset("rst_midwrite");
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0; we = 1'b0;
        cyc(1'b0, 3'd0, 16'h0000, 2'b00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
